uart_tx_arbiter: RTL and testbench

- Shares one uart_tx serializer between NUM_REQ byte-stream requesters.
- Arbitration is round-robin at packet granularity: once granted, a requester keeps the transmitter until its byte marked last has fully left the line.
- Sits between client logic (command responders, debug printers) and uart_tx. It sequences the send/tx_done handshake and holds the data byte stable for the whole frame.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_tx arbiter.
// Index arithmetic wraps modulo the requester count.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ARB,
        LOAD,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid index at or after ptr.
// Produces a one-hot grant plus the binary index of the winner.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    int   pos;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = int'(ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && valid[pos]) begin
                gnt[pos] = 1'b1;
                idx      = IDX_W'(pos);
                found    = 1'b1;
            end
            pos = rr_next(pos, NUM_REQ);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx among NUM_REQ clients.
// Define UART_ARB_TIMEOUT_EN to abort packets whose owner stalls mid-packet.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      uart_send,
    output logic [BYTE_W-1:0]         uart_data,
    input  logic                      uart_tx_done
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                      timeout_err
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported parameters");
    end

    arb_state_t         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [BYTE_W-1:0]  data_q, data_d;
    logic               last_q, last_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   ptr_after;
    logic [BYTE_W-1:0]  sel_byte;
    logic               tmo_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .valid (req_valid),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx)
    );

    assign ptr_after = IDX_W'(rr_next(int'(gidx_q), NUM_REQ));
    assign sel_byte  = req_data[gidx_q*BYTE_W +: BYTE_W];

    assign req_ready = (state_q == LOAD) ? grant_q : '0;
    assign grant     = grant_q;
    assign busy      = (state_q != ARB);
    assign uart_send = (state_q == SEND);
    assign uart_data = data_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_err_q;
    logic             load_idle;

    assign load_idle = (state_q == LOAD) && !req_valid[gidx_q];
    assign tmo_hit   = load_idle && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_err_q <= tmo_hit;
            if (load_idle && !tmo_hit)
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            else
                tmo_cnt_q <= '0;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        data_d  = data_q;
        last_d  = last_q;
        unique case (state_q)
            ARB: begin
                if (uart_tx_done && |req_valid) begin
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (req_valid[gidx_q]) begin
                    data_d  = sel_byte;
                    last_d  = req_last[gidx_q];
                    state_d = SEND;
                end else if (tmo_hit) begin
                    grant_d = '0;
                    ptr_d   = ptr_after;
                    state_d = ARB;
                end
            end
            SEND: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!uart_tx_done)
                    state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (uart_tx_done) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = ptr_after;
                        state_d = ARB;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB;
            grant_q <= '0;
            ptr_q   <= '0;
            gidx_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a 16 clk/bit uart_tx model.
// Build with UART_ARB_TIMEOUT_EN to also exercise the starvation timeout.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N = 4;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int GAP = 15;
`else
    localparam int GAP = 40;
`endif

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [N*8-1:0] req_data;
    logic           busy, uart_send, uart_tx_done;
    logic [7:0]     uart_data;
`ifdef UART_ARB_TIMEOUT_EN
    logic           timeout_err;
    int             tmo_cnt = 0;
    int             tmo_cyc = 0;
    logic [N-1:0]   tmo_grant = '0;
`endif

    logic       dv [N];
    logic [7:0] dd [N];
    logic       dl [N];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int send_cnt = 0;
    int rdy_rise [N];
    int rdy1_cyc = 0;

    typedef struct packed {
        logic [7:0]   d;
        logic [N-1:0] g;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] line_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = dv[i];
            req_last[i]         = dl[i];
            req_data[i*8 +: 8]  = dd[i];
        end
    end

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .grant        (grant),
        .busy         (busy),
        .uart_send    (uart_send),
        .uart_data    (uart_data),
        .uart_tx_done (uart_tx_done)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    // uart_tx stand-in: reads uart_data live every bit, so instability corrupts the line
    logic tx_busy;
    int   tx_cnt, tx_bit;
    logic line;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_busy <= 1'b0;
            tx_cnt  <= 0;
            tx_bit  <= 0;
        end else if (!tx_busy) begin
            if (uart_send) begin
                tx_busy <= 1'b1;
                tx_cnt  <= 0;
                tx_bit  <= 0;
            end
        end else if (tx_cnt == 15) begin
            tx_cnt <= 0;
            if (tx_bit == 9) tx_busy <= 1'b0;
            else tx_bit <= tx_bit + 1;
        end else begin
            tx_cnt <= tx_cnt + 1;
        end
    end

    assign uart_tx_done = !tx_busy;

    always_comb begin
        line = 1'b1;
        if (tx_busy) begin
            if (tx_bit == 0) line = 1'b0;
            else if (tx_bit <= 8) line = uart_data[tx_bit-1];
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic expect_tx(input logic [7:0] d, input int r);
        exp_t e;
        e.d = d;
        e.g = '0;
        e.g[r] = 1'b1;
        exp_q.push_back(e);
    endtask

    // send monitor: pops the scoreboard on every uart_send pulse
    initial begin : mon
        exp_t e;
        logic [N-1:0] rdy_prev;
        rdy_prev = '0;
        for (int i = 0; i < N; i++) rdy_rise[i] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rdy_prev = '0;
            end else begin
                if (uart_send) begin
                    send_cnt++;
                    chk("send_while_tx_idle", uart_tx_done, 1);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_send data=%h grant=%b", uart_data, grant);
                    end else begin
                        e = exp_q.pop_front();
                        if (uart_data !== e.d || grant !== e.g) begin
                            errors++;
                            $display("FAIL send_byte got data=%h grant=%b exp data=%h grant=%b",
                                     uart_data, grant, e.d, e.g);
                        end
                        line_q.push_back(e.d);
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i] && !rdy_prev[i]) begin
                        rdy_rise[i]++;
                        if (i == 1) rdy1_cyc = cyc;
                    end
                end
                rdy_prev = req_ready;
`ifdef UART_ARB_TIMEOUT_EN
                if (timeout_err) begin
                    tmo_cnt++;
                    tmo_cyc   = cyc;
                    tmo_grant = grant;
                end
`endif
            end
        end
    end

    // serial line decoder: start bit, 8 data bits LSB first, stop bit
    logic rx_act = 1'b0;

    initial begin : rx
        int         rx_cnt;
        int         k;
        logic [7:0] rx_sh;
        logic [7:0] ev;
        rx_cnt = 0;
        rx_sh  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_act = 1'b0;
            end else if (!rx_act) begin
                if (!line) begin
                    rx_act = 1'b1;
                    rx_cnt = 1;
                end
            end else begin
                if (rx_cnt % 16 == 7) begin
                    k = rx_cnt / 16;
                    if (k == 0) begin
                        chk("start_bit", line, 0);
                    end else if (k <= 8) begin
                        rx_sh[k-1] = line;
                    end else begin
                        checks++;
                        if (line_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_frame byte=%h", rx_sh);
                        end else begin
                            ev = line_q.pop_front();
                            if (rx_sh !== ev || line !== 1'b1) begin
                                errors++;
                                $display("FAIL line_byte got=%h stop=%b exp=%h stop=1",
                                         rx_sh, line, ev);
                            end
                        end
                        rx_act = 1'b0;
                    end
                end
                rx_cnt++;
            end
        end
    end

    task automatic send_pkt(input int r, input int n, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2,
                            input logic [2:0] lm, input int gap);
        logic [7:0] bs [3];
        int t;
        int s;
        bs[0] = b0;
        bs[1] = b1;
        bs[2] = b2;
        for (int k = 0; k < n; k++) begin
            if (k == 1 && gap > 0) begin
                t = 0;
                while (!req_ready[r] && t < 5000) begin
                    @(negedge clk);
                    t++;
                end
                s = send_cnt;
                repeat (gap) @(negedge clk);
                chk("gap_no_send", send_cnt - s, 0);
                chk("gap_still_ready", req_ready, 1 << r);
            end
            dv[r] = 1'b1;
            dd[r] = bs[k];
            dl[r] = lm[k];
            t = 0;
            while (!req_ready[r] && t < 5000) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (t >= 5000) begin
                errors++;
                $display("FAIL accept_timeout req=%0d byte=%0d", r, k);
                dv[r] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            dv[r] = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || line_q.size() != 0 || busy ||
                !uart_tx_done || rx_act) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 20000) begin
            errors++;
            $display("FAIL wait_idle_timeout exp_q=%0d line_q=%0d busy=%b",
                     exp_q.size(), line_q.size(), busy);
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        line_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin : stim
        int s0;
        int t;
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            dv[i] = 1'b0;
            dd[i] = '0;
            dl[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_send", uart_send, 0);
        chk("rst_data", uart_data, 0);
`ifdef UART_ARB_TIMEOUT_EN
        chk("rst_timeout_err", timeout_err, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // single-byte packet
        s0 = send_cnt;
        expect_tx(8'hA5, 0);
        send_pkt(0, 1, 8'hA5, 8'h00, 8'h00, 3'b001, 0);
        wait_idle();
        chk("t1_sends", send_cnt - s0, 1);
        chk("t1_grant_released", grant, 0);

        // four simultaneous 2-byte packets
        pulse_rst();
        s0 = send_cnt;
        for (int i = 0; i < N; i++) begin
            expect_tx(8'h10 + 8'(i), i);
            expect_tx(8'h20 + 8'(i), i);
        end
        fork
            send_pkt(0, 2, 8'h10, 8'h20, 8'h00, 3'b010, 0);
            send_pkt(1, 2, 8'h11, 8'h21, 8'h00, 3'b010, 0);
            send_pkt(2, 2, 8'h12, 8'h22, 8'h00, 3'b010, 0);
            send_pkt(3, 2, 8'h13, 8'h23, 8'h00, 3'b010, 0);
        join
        wait_idle();
        chk("t2_sends", send_cnt - s0, 8);

        // pointer wrap: after req2, req0 wins over req2
        s0 = send_cnt;
        expect_tx(8'h30, 2);
        send_pkt(2, 1, 8'h30, 8'h00, 8'h00, 3'b001, 0);
        wait_idle();
        expect_tx(8'h40, 0);
        expect_tx(8'h41, 2);
        fork
            send_pkt(0, 1, 8'h40, 8'h00, 8'h00, 3'b001, 0);
            send_pkt(2, 1, 8'h41, 8'h00, 8'h00, 3'b001, 0);
        join
        wait_idle();
        chk("t3_sends", send_cnt - s0, 3);

        // stalled 3-byte packet from req3 blocks req0
        s0 = send_cnt;
        for (int i = 0; i < N; i++) rdy_rise[i] = 0;
        expect_tx(8'h50, 3);
        expect_tx(8'h51, 3);
        expect_tx(8'h52, 3);
        expect_tx(8'h60, 0);
        fork
            send_pkt(3, 3, 8'h50, 8'h51, 8'h52, 3'b100, GAP);
            send_pkt(0, 1, 8'h60, 8'h00, 8'h00, 3'b001, 0);
        join
        wait_idle();
        chk("t5_sends", send_cnt - s0, 4);
        chk("t5_ready3_pulses", rdy_rise[3], 3);
        chk("t5_ready0_pulses", rdy_rise[0], 1);

        // reset during WAIT_DONE of req1 byte 2
        expect_tx(8'h70, 1);
        expect_tx(8'h71, 1);
        send_pkt(1, 2, 8'h70, 8'h71, 8'h00, 3'b010, 0);
        t = 0;
        while (!(busy && !uart_tx_done) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        repeat (50) @(negedge clk);
        chk("t4_in_wait_done", {busy, uart_tx_done, uart_data}, {2'b10, 8'h71});
        rst = 1'b1;
        #1;
        chk("t4_rst_ready", req_ready, 0);
        chk("t4_rst_grant", grant, 0);
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_send", uart_send, 0);
        chk("t4_rst_data", uart_data, 0);
        exp_q.delete();
        line_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s0 = send_cnt;
        expect_tx(8'h80, 1);
        expect_tx(8'h81, 1);
        expect_tx(8'h90, 2);
        fork
            send_pkt(1, 2, 8'h80, 8'h81, 8'h00, 3'b010, 0);
            send_pkt(2, 1, 8'h90, 8'h00, 8'h00, 3'b001, 0);
        join
        wait_idle();
        chk("t4_sends", send_cnt - s0, 3);

`ifdef UART_ARB_TIMEOUT_EN
        // req1 abandons its packet; req2 is served after the abort
        s0 = send_cnt;
        tmo_cnt = 0;
        expect_tx(8'hA0, 1);
        expect_tx(8'hB0, 2);
        fork
            send_pkt(1, 1, 8'hA0, 8'h00, 8'h00, 3'b000, 0);
            send_pkt(2, 1, 8'hB0, 8'h00, 8'h00, 3'b001, 0);
        join
        wait_idle();
        chk("t6_sends", send_cnt - s0, 2);
        chk("t6_timeout_pulses", tmo_cnt, 1);
        chk("t6_timeout_latency", tmo_cyc - rdy1_cyc, 20);
        chk("t6_grant_at_timeout", tmo_grant, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
